// File: rtl/lab3_mem_bank_mem_arbiter.sv
// Round-robin merge of per-bank 16B memory requests onto one memory port, with
// bank id carried in opaque[7:6] so responses are routed back to the issuing bank.
module lab3_mem_bank_mem_arbiter #(
    parameter int p_num_banks = 4
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic [p_num_banks-1:0][174:0] bank_reqstream_msg,
    input  logic [p_num_banks-1:0]        bank_reqstream_val,
    output logic [p_num_banks-1:0]        bank_reqstream_rdy,

    output logic [p_num_banks-1:0][144:0] bank_respstream_msg,
    output logic [p_num_banks-1:0]        bank_respstream_val,
    input  logic [p_num_banks-1:0]        bank_respstream_rdy,

    output logic [174:0]                  mem_reqstream_msg,
    output logic                          mem_reqstream_val,
    input  logic                          mem_reqstream_rdy,

    input  logic [144:0]                  mem_respstream_msg,
    input  logic                          mem_respstream_val,
    output logic                          mem_respstream_rdy
);

    localparam int NB = p_num_banks;

    // Bit positions of opaque[7:6] inside the request and response messages.
    localparam int REQ_OPQ_HI  = 171;
    localparam int RESP_OPQ_HI = 141;

    logic             buf_full_q, buf_full_d;
    logic [174:0]     buf_msg_q,  buf_msg_d;
    logic [3:0]       pending_q,  pending_d;
    logic [3:0][1:0]  saved_q,    saved_d;
    logic [1:0]       prio_q,     prio_d;

    logic [3:0]       bank_val_w;
    logic [3:0]       bank_resp_rdy_w;
    logic [3:0]       eligible;
    logic             can_grant;
    logic             gnt_found;
    logic [1:0]       gnt_id;
    logic [1:0]       scan_idx;
    logic             grant;
    logic [174:0]     gnt_msg;
    logic             deq;

    logic [1:0]       resp_bank;
    logic             resp_legal;
    logic             resp_hs;
    logic [144:0]     resp_fixed;

    // Internal per-bank vectors are always four wide; unused banks read as idle.
    always_comb begin
        bank_val_w      = '0;
        bank_resp_rdy_w = '0;
        for (int i = 0; i < NB; i++) begin
            bank_val_w[i]      = bank_reqstream_val[i];
            bank_resp_rdy_w[i] = bank_respstream_rdy[i];
        end
    end

    assign eligible          = bank_val_w & ~pending_q;
    assign mem_reqstream_val = buf_full_q & ~reset;
    assign mem_reqstream_msg = buf_msg_q;
    assign deq               = mem_reqstream_val & mem_reqstream_rdy;
    assign can_grant         = ~reset & (~buf_full_q | mem_reqstream_rdy);

    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_idx  = '0;
        for (int k = 0; k < NB; k++) begin
            scan_idx = 2'((int'(prio_q) + k) % NB);
            if (!gnt_found && eligible[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_id    = scan_idx;
            end
        end
    end

    assign grant = can_grant & gnt_found;

    always_comb begin
        bank_reqstream_rdy = '0;
        gnt_msg            = '0;
        for (int i = 0; i < NB; i++) begin
            if (2'(i) == gnt_id) begin
                bank_reqstream_rdy[i] = grant;
                gnt_msg               = bank_reqstream_msg[i];
            end
        end
    end

    // Response routing is purely combinational so responses see no added latency.
    assign resp_bank  = mem_respstream_msg[RESP_OPQ_HI -: 2];
    assign resp_legal = (int'(resp_bank) < NB) && pending_q[resp_bank];

    always_comb begin
        resp_fixed                     = mem_respstream_msg;
        resp_fixed[RESP_OPQ_HI -: 2]   = saved_q[resp_bank];
    end

    always_comb begin
        bank_respstream_val = '0;
        bank_respstream_msg = '0;
        mem_respstream_rdy  = 1'b0;
        if (!reset) begin
            if (resp_legal) begin
                mem_respstream_rdy = bank_resp_rdy_w[resp_bank];
                for (int i = 0; i < NB; i++) begin
                    if (2'(i) == resp_bank) begin
                        bank_respstream_val[i] = mem_respstream_val;
                        bank_respstream_msg[i] = resp_fixed;
                    end
                end
            end else begin
                mem_respstream_rdy = 1'b1;
            end
        end
    end

    assign resp_hs = mem_respstream_val & mem_respstream_rdy & resp_legal;

    always_comb begin
        buf_full_d = buf_full_q;
        buf_msg_d  = buf_msg_q;
        pending_d  = pending_q;
        saved_d    = saved_q;
        prio_d     = prio_q;

        if (deq) begin
            buf_full_d = 1'b0;
        end
        // A bank being granted is never pending, so the clear and set cannot collide.
        if (resp_hs) begin
            pending_d[resp_bank] = 1'b0;
        end
        if (grant) begin
            buf_full_d                  = 1'b1;
            buf_msg_d                   = gnt_msg;
            buf_msg_d[REQ_OPQ_HI -: 2]  = gnt_id;
            saved_d[gnt_id]             = gnt_msg[REQ_OPQ_HI -: 2];
            pending_d[gnt_id]           = 1'b1;
            prio_d                      = 2'((int'(gnt_id) + 1) % NB);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational blocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full_q <= 1'b0;
            pending_q  <= '0;
            saved_q    <= '0;
            prio_q     <= '0;
        end else begin
            buf_full_q <= buf_full_d;
            pending_q  <= pending_d;
            saved_q    <= saved_d;
            prio_q     <= prio_d;
        end
    end

    // NOTE: the payload register is not reset; buf_full_q alone qualifies it.
    always_ff @(posedge clk) begin
        buf_msg_q <= buf_msg_d;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && mem_respstream_val && !resp_legal) begin
            $display("lab3_mem_bank_mem_arbiter: error: dropped response for bank %0d with no pending request",
                     resp_bank);
        end
    end

    function automatic string line_trace();
        string gnt_str;
        gnt_str = grant ? $sformatf("%0d", gnt_id) : ".";
        return $sformatf("%s%s%h", gnt_str, buf_full_q ? "F" : " ", pending_q);
    endfunction
`endif

endmodule
